// File: rtl/clint_pkg.sv
// Core-local interruptor shared definitions.
// Register offsets, pending-bit positions, reset constants.
package clint_pkg;

  localparam logic [15:0] MSIP_OFF        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

  localparam int MTIP_BIT = 7;
  localparam int MSIP_BIT = 3;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Word-granular match; byte-lane bits are ignored.
  function automatic logic hit(
    input logic [15:0] a,
    input logic [15:0] off
  );
    return a[15:2] == off[15:2];
  endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// Divides the core clock into mtime tick pulses.
// Ports: clk, reset_n (async low), tick (one cycle every TICK_DIV).
module clint_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: mtime, mtimecmp, msip on a 0-wait bus.
// Ports: clk, reset_n, sel/we/addr/wdata/rdata/ack bus, mip_out.
import clint_pkg::*;

module clint #(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sel,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic [31:0] mip_out
);

  logic        tick;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic [31:0] hi_shadow;

  logic        wr;
  logic        rd;
  logic        a_msip;
  logic        a_cmp_lo;
  logic        a_cmp_hi;
  logic        a_tim_lo;
  logic        a_tim_hi;
  logic [31:0] rd_mux;
  logic [31:0] mip_nxt;
  logic        unused_ok;

  clint_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  assign unused_ok = ^addr[1:0];

  assign wr = sel & we;
  assign rd = sel & ~we;

  assign a_msip   = hit(addr, MSIP_OFF);
  assign a_cmp_lo = hit(addr, MTIMECMP_LO_OFF);
  assign a_cmp_hi = hit(addr, MTIMECMP_HI_OFF);
  assign a_tim_lo = hit(addr, MTIME_LO_OFF);
  assign a_tim_hi = hit(addr, MTIME_HI_OFF);

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      a_msip:   rd_mux = {31'd0, msip};
      a_cmp_lo: rd_mux = mtimecmp[31:0];
      a_cmp_hi: rd_mux = mtimecmp[63:32];
      a_tim_lo: rd_mux = mtime[31:0];
      a_tim_hi: rd_mux = hi_shadow;
      default:  rd_mux = '0;
    endcase
  end

  // Compare uses registered values, so pending lags a change by one edge.
  always_comb begin
    mip_nxt           = '0;
    mip_nxt[MTIP_BIT] = (mtime >= mtimecmp);
    mip_nxt[MSIP_BIT] = msip;
  end

  // A software write to either half wins over the tick increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mtime <= '0;
    end else if (wr && a_tim_lo) begin
      mtime[31:0] <= wdata;
    end else if (wr && a_tim_hi) begin
      mtime[63:32] <= wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mtimecmp <= MTIMECMP_RST;
      msip     <= 1'b0;
    end else if (wr) begin
      if (a_cmp_lo) mtimecmp[31:0]  <= wdata;
      if (a_cmp_hi) mtimecmp[63:32] <= wdata;
      if (a_msip)   msip            <= wdata[0];
    end
  end

  // Low-word read freezes the high word for a tear-free 64-bit read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_shadow <= '0;
    end else if (rd && a_tim_lo) begin
      hi_shadow <= mtime[63:32];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack     <= 1'b0;
      rdata   <= '0;
      mip_out <= '0;
    end else begin
      ack     <= sel;
      rdata   <= rd ? rd_mux : 32'd0;
      mip_out <= mip_nxt;
    end
  end

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint: table-driven register map
// plus directed timer, interrupt, shadow and reset sequences.
module tb_clint;

  logic        clk;
  logic        reset_n;
  logic        sel;
  logic        we;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata1, rdata4;
  logic        ack1, ack4;
  logic [31:0] mip1, mip4;

  int total;
  int bad;
  int cyc;

  clint #(.TICK_DIV(1)) dut1 (
    .clk    (clk),
    .reset_n(reset_n),
    .sel    (sel),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata1),
    .ack    (ack1),
    .mip_out(mip1)
  );

  clint #(.TICK_DIV(4)) dut4 (
    .clk    (clk),
    .reset_n(reset_n),
    .sel    (sel),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata4),
    .ack    (ack4),
    .mip_out(mip4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges seen since reset release; equals dut1 mtime absent writes.
  always @(posedge clk) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    sel = 1'b0;
    we = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    sel = 1'b1;
    we = 1'b1;
    addr = a;
    wdata = d;
    @(negedge clk);
    sel = 1'b0;
    we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d1,
                    output logic [31:0] d4, output logic a1);
    sel = 1'b1;
    we = 1'b0;
    addr = a;
    @(negedge clk);
    sel = 1'b0;
    d1 = rdata1;
    d4 = rdata4;
    a1 = ack1;
  endtask

  logic [31:0] d1, d4;
  logic        a1;
  int          c;
  bit          found;

  initial begin
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    sel = 1'b0;
    we = 1'b0;
    addr = '0;
    wdata = '0;

    tbl[0]  = '{1'b1, 16'h0000, 32'h0000_0001, 32'h0};
    tbl[1]  = '{1'b0, 16'h0000, 32'h0, 32'h0000_0001};
    tbl[2]  = '{1'b1, 16'h0000, 32'hFFFF_FFFE, 32'h0};
    tbl[3]  = '{1'b0, 16'h0000, 32'h0, 32'h0000_0000};
    tbl[4]  = '{1'b1, 16'h0000, 32'hFFFF_FFFF, 32'h0};
    tbl[5]  = '{1'b0, 16'h0002, 32'h0, 32'h0000_0001};
    tbl[6]  = '{1'b1, 16'h4000, 32'h1234_5678, 32'h0};
    tbl[7]  = '{1'b0, 16'h4000, 32'h0, 32'h1234_5678};
    tbl[8]  = '{1'b1, 16'h4004, 32'hCAFE_F00D, 32'h0};
    tbl[9]  = '{1'b0, 16'h4004, 32'h0, 32'hCAFE_F00D};
    tbl[10] = '{1'b0, 16'h4003, 32'h0, 32'h1234_5678};
    tbl[11] = '{1'b1, 16'h1234, 32'hDEAD_BEEF, 32'h0};
    tbl[12] = '{1'b0, 16'h1234, 32'h0, 32'h0000_0000};
    tbl[13] = '{1'b0, 16'h4008, 32'h0, 32'h0000_0000};
    tbl[14] = '{1'b1, 16'h0000, 32'h0000_0000, 32'h0};
    tbl[15] = '{1'b0, 16'h0000, 32'h0, 32'h0000_0000};

    // Reset state
    #1;
    chk("rst_ack", {63'd0, ack1}, 64'd0);
    chk("rst_rdata", {32'd0, rdata1}, 64'd0);
    chk("rst_mip", {32'd0, mip1}, 64'd0);
    do_reset();

    // Idle 10 cycles, mtime about 10, mtimecmp at all ones
    repeat (10) @(negedge clk);
    rd(16'hBFF8, d1, d4, a1);
    total++;
    if (!(d1 >= 32'd9 && d1 <= 32'd11)) begin
      bad++;
      $display("FAIL idle_mtime: got %0d want 10+-1", d1);
    end
    chk("idle_mip", {32'd0, mip1}, 64'd0);
    rd(16'h4000, d1, d4, a1);
    chk("cmp_lo_rst", {32'd0, d1}, 64'hFFFF_FFFF);
    rd(16'h4004, d1, d4, a1);
    chk("cmp_hi_rst", {32'd0, d1}, 64'hFFFF_FFFF);

    // Register map table
    do_reset();
    foreach (tbl[i]) begin
      if (tbl[i].we) begin
        wr(tbl[i].addr, tbl[i].wdata);
      end else begin
        rd(tbl[i].addr, d1, d4, a1);
        chk($sformatf("tbl%0d_d1", i), {32'd0, d1}, {32'd0, tbl[i].exp});
        chk($sformatf("tbl%0d_d4", i), {32'd0, d4}, {32'd0, tbl[i].exp});
      end
    end

    // MTIP rises one edge after mtime reaches mtimecmp
    do_reset();
    wr(16'h4000, 32'h20);
    wr(16'h4004, 32'h0);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mip1[7]) begin
        found = 1;
        break;
      end
    end
    chk("mtip_seen", {63'd0, found}, 64'd1);
    chk("mtip_rise_cyc", 64'(cyc), 64'd33);
    wr(16'h4004, 32'h1);
    chk("mtip_hold_n", {63'd0, mip1[7]}, 64'd1);
    @(negedge clk);
    chk("mtip_fall_n1", {63'd0, mip1[7]}, 64'd0);

    // MSIP path
    wr(16'h0000, 32'h1);
    chk("msip_lat_n", {32'd0, mip1}, 64'd0);
    @(negedge clk);
    chk("msip_set", {32'd0, mip1}, 64'h8);
    rd(16'h0000, d1, d4, a1);
    chk("msip_rd1", {32'd0, d1}, 64'h1);
    wr(16'h0000, 32'h0);
    chk("msip_clr_n", {32'd0, mip1}, 64'h8);
    @(negedge clk);
    chk("msip_clr", {32'd0, mip1}, 64'd0);
    rd(16'h0000, d1, d4, a1);
    chk("msip_rd0", {32'd0, d1}, 64'h0);

    // mtime carry into high word
    do_reset();
    wr(16'hBFF8, 32'hFFFF_FFFE);
    wr(16'hBFFC, 32'h0000_0005);
    repeat (3) @(negedge clk);
    rd(16'hBFF8, d1, d4, a1);
    chk("wrap_lo", {32'd0, d1}, 64'h1);
    repeat (5) @(negedge clk);
    rd(16'hBFFC, d1, d4, a1);
    chk("wrap_hi", {32'd0, d1}, 64'h6);

    // Shadow holds across a live carry
    wr(16'hBFFC, 32'h7);
    wr(16'hBFF8, 32'hFFFF_FFFD);
    rd(16'hBFF8, d1, d4, a1);
    chk("shd_lo", {32'd0, d1}, 64'hFFFF_FFFD);
    repeat (5) @(negedge clk);
    rd(16'hBFFC, d1, d4, a1);
    chk("shd_hi_old", {32'd0, d1}, 64'h7);
    rd(16'hBFF8, d1, d4, a1);
    chk("shd_lo2", {32'd0, d1}, 64'h4);
    rd(16'hBFFC, d1, d4, a1);
    chk("shd_hi_new", {32'd0, d1}, 64'h8);

    // TICK_DIV = 4 pacing
    do_reset();
    for (int i = 0; i < 8; i++) begin
      c = cyc;
      rd(16'hBFF8, d1, d4, a1);
      chk($sformatf("div4_r%0d", i), {32'd0, d4}, 64'(c / 4));
      chk($sformatf("div1_r%0d", i), {32'd0, d1}, 64'(c));
    end
    // Write landing on a tick edge loads exactly wdata
    for (int i = 0; i < 8 && (cyc % 4) != 3; i++) @(negedge clk);
    chk("div4_phase", 64'(cyc % 4), 64'd3);
    wr(16'hBFF8, 32'h100);
    rd(16'hBFF8, d1, d4, a1);
    chk("div4_wr_tick", {32'd0, d4}, 64'h100);

    // Back-to-back reads
    do_reset();
    wr(16'h0000, 32'h1);
    rd(16'h0000, d1, d4, a1);
    chk("b2b_ack0", {63'd0, a1}, 64'd1);
    chk("b2b_d0", {32'd0, d1}, 64'h1);
    rd(16'h4000, d1, d4, a1);
    chk("b2b_ack1", {63'd0, a1}, 64'd1);
    chk("b2b_d1", {32'd0, d1}, 64'hFFFF_FFFF);
    rd(16'h1234, d1, d4, a1);
    chk("b2b_ack2", {63'd0, a1}, 64'd1);
    chk("b2b_d2", {32'd0, d1}, 64'h0);
    @(negedge clk);
    chk("b2b_idle", {63'd0, ack1}, 64'd0);

    // Async reset during second read
    sel = 1'b1;
    we = 1'b0;
    addr = 16'h0000;
    @(negedge clk);
    chk("ar_ack_pre", {63'd0, ack1}, 64'd1);
    chk("ar_mip_pre", {32'd0, mip1}, 64'h8);
    addr = 16'h4000;
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_ack", {63'd0, ack1}, 64'd0);
    chk("ar_rdata", {32'd0, rdata1}, 64'd0);
    chk("ar_mip", {32'd0, mip1}, 64'd0);
    sel = 1'b0;
    @(negedge clk);
    chk("ar_ack_drop", {63'd0, ack1}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
